// File: rtl/wait_timer.sv
// wait_timer: programmable one-shot delay timer.
// A start strobe loads a delay; a single-cycle pulse marks its expiry.
module wait_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] tick,
   output logic             out,
   output logic             busy,
   output logic [WIDTH-1:0] remaining
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             out_q, out_d;
   logic             go;

   // Unknown start levels count as "no start"
   assign go = (start === 1'b1);

   // State, counter and pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         count_q <= '0;
         out_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         out_q   <= out_d;
      end
   end

   // Next state: restart wins over expiry; tick=0 behaves as tick=1
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      out_d   = 1'b0;
      if (go) begin
         state_d = S_RUN;
         if (tick == '0) begin
            count_d = '0;
         end else begin
            count_d = tick - 1'b1;
         end
      end else begin
         unique case (state_q)
            S_RUN: begin
               if (count_q != '0) begin
                  count_d = count_q - 1'b1;
               end else begin
                  state_d = S_IDLE;
                  out_d   = 1'b1;
               end
            end
            default: begin
               count_d = '0;
            end
         endcase
      end
   end

   assign out       = out_q;
   assign busy      = (state_q == S_RUN);
   assign remaining = count_q;

endmodule

// File: tb/tb_wait_timer.sv
// Bench for wait_timer: expected pulse cycles are queued by the
// stimulus and matched by a monitor against every observed pulse.
module tb_wait_timer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] tick;
   logic       out;
   logic       busy;
   logic [3:0] remaining;

   int checks;
   int errors;
   int cyc;
   int exp_q[$];

   wait_timer #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .tick      (tick),
      .out       (out),
      .busy      (busy),
      .remaining (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge counter: after edge e, cyc == e
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every pulse must match the oldest expected cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (exp_q.size() > 0 && cyc > exp_q[0]) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse: out stayed 0, required 1 at cycle %0d",
                     exp_q[0]);
            void'(exp_q.pop_front());
         end
         if (out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL spurious_pulse: out=1 at cycle %0d, required none",
                        cyc);
            end else begin
               if (exp_q[0] != cyc) begin
                  errors++;
                  $display("FAIL pulse_time: got cycle %0d, required %0d",
                           cyc, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // One-cycle start; returns at the negedge where cyc == k
   task automatic pulse_start(input logic [3:0] t, output int k);
      @(negedge clk);
      start = 1'b1;
      tick  = t;
      k     = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      tick  = 4'hA;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int k, k2, ones;

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      start  = 1'b0;
      tick   = 4'd0;
      rst    = 1'b1;
      #1;
      chk("rst_out", out, 0);
      chk("rst_busy", busy, 0);
      chk("rst_rem", remaining, 0);
      idle(2);
      rst = 1'b0;
      idle(2);
      chk("idle_busy", busy, 0);

      // Basic delay tick=3: remaining 2,1,0 then pulse at k+3
      pulse_start(4'd3, k);
      exp_q.push_back(k + 3);
      chk("basic_busy0", busy, 1);
      chk("basic_rem0", remaining, 2);
      idle(1);
      chk("basic_rem1", remaining, 1);
      idle(1);
      chk("basic_rem2", remaining, 0);
      chk("basic_busy2", busy, 1);
      idle(1);
      chk("basic_busy3", busy, 0);
      chk("basic_rem3", remaining, 0);
      idle(6);

      // tick=0 behaves as tick=1
      pulse_start(4'd0, k);
      chk("t0_rem", remaining, 0);
      exp_q.push_back(k + 1);
      idle(5);

      // tick=1
      pulse_start(4'd1, k);
      exp_q.push_back(k + 1);
      idle(5);

      // Maximum tick=15
      pulse_start(4'd15, k);
      chk("t15_rem", remaining, 14);
      exp_q.push_back(k + 15);
      idle(20);

      // Restart: tick=4 at k, tick=2 at k+2 -> pulse at k+4 only
      pulse_start(4'd4, k);
      pulse_start(4'd2, k2);
      chk("restart_edge", k2, k + 2);
      exp_q.push_back(k + 4);
      idle(10);

      // Collision: tick=2 at k, restart tick=2 at k+2 -> pulse at k+4
      pulse_start(4'd2, k);
      pulse_start(4'd2, k2);
      exp_q.push_back(k + 4);
      idle(10);

      // Start held for 3 edges with tick=3 -> pulse at k+5
      @(negedge clk);
      start = 1'b1;
      tick  = 4'd3;
      k     = cyc + 1;
      idle(3);
      start = 1'b0;
      tick  = 4'd7;
      exp_q.push_back(k + 5);
      chk("held_rem", remaining, 2);
      idle(10);

      // Asynchronous reset mid-count: no pulse afterwards
      pulse_start(4'd5, k);
      idle(1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_out", out, 0);
      chk("arst_busy", busy, 0);
      chk("arst_rem", remaining, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(10);
      chk("arst_idle_busy", busy, 0);

      // Controller use: poll out, expect exactly one high cycle
      pulse_start(4'd3, k);
      exp_q.push_back(k + 3);
      ones = 0;
      repeat (20) begin
         if (out === 1'b1) ones++;
         @(negedge clk);
      end
      chk("ctrl_ones", ones, 1);

      chk("queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time limit
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish");
      $fatal(1);
   end

endmodule

// File: doc/wait_timer.md
Name: wait_timer

Overview:
- Programmable one-shot delay timer.
- A start strobe loads a cycle count; when the count elapses, the block emits a single-cycle timeout pulse.
- The LED controller uses it to time the latch (lat) high period: it pulses start, then waits in its WAIT_LAT state until out is 1.

Parameters:
- WIDTH, 4, bit width of the tick input and the internal down-counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  start/restart strobe, sampled on the rising edge of clk.
- tick  input  WIDTH  delay length in clk cycles, sampled only when start is high.
- out  output  1  timeout pulse, registered, high for exactly one cycle.
- busy  output  1  high while a countdown is in progress, registered.
- remaining  output  WIDTH  current down-counter value, for debug and observation.

Behaviour:
- Reset (rst=1, asynchronous, any time):
  - count=0, busy=0, out=0.
  - Any countdown in progress is abandoned and no pulse is emitted.
  - On release, the block is idle until the next start.
- Effective delay N = tick, except tick=0 is treated as N=1.
- Start at edge k (start=1):
  - Load count=N-1 and set busy=1.
  - out is 0 after edge k, even if a pulse would otherwise have been issued at that edge; restart wins.
- Counting, while busy=1 and start=0 at an edge:
  - If count>0: count decrements by 1, out=0.
  - If count=0: busy goes to 0 and out goes to 1.
- Timing: out is high during the cycle following edge k+N, and only that cycle. Example: tick=3, start seen at edge k, so out=1 between edges k+3 and k+4.
- Next edge after the pulse: out returns to 0 unconditionally.
- Idle (busy=0, start=0): count holds at 0, out=0. No spurious pulses.
- tick changes while busy are ignored; only the value sampled with start matters.
- start held high for multiple cycles: each edge reloads, so the pulse occurs N edges after the last edge where start=1.
- Start arriving at the same edge as the pulse-generating edge: the reload takes priority, no pulse is issued, and the new countdown begins.
- remaining mirrors count. It is 0 when idle.
- Maximum delay is 2^WIDTH-1 cycles. Counter arithmetic is unsigned and never wraps below 0.
- All outputs are driven from flops; there are no combinational paths from inputs to outputs.
- start=X or Z is treated as 0 in simulation.

Test Plan:
- Reset behaviour: assert rst mid-count with tick=5, start pulsed 2 edges earlier → out=0, busy=0 and remaining=0 immediately. No pulse after release.
- Basic delay: tick=3, one-cycle start at edge k → out=1 only between edges k+3 and k+4; busy=1 from k to k+3; remaining sequence 2,1,0.
- Boundary values:
  - tick=0 → out pulse after edge k+1 (same as tick=1).
  - tick=15 → pulse after edge k+15.
- Restart: tick=4 start at k, then tick=2 start at k+2 → single pulse after edge k+4; no pulse at k+4 from the first start sequence.
- Collision and held start:
  - tick=2 start at k, new start at k+2 → no pulse at k+2, pulse after k+4.
  - start held high for 3 cycles with tick=3 → one pulse, 3 edges after the last start edge.
- Controller use case: start=1 with tick=3 for one cycle; poll out each cycle → exactly one out=1 cycle is observed, then out stays 0 indefinitely.
